// File: rtl/pc_pkg.sv
//------------------------------------------------------------------------------
// Module : pc_pkg
// Brief  : Shared op encodings and sizing helpers for the PC sequencer slice.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pc_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_INC  = 3'd0;
    localparam logic [OP_W-1:0] OP_HOLD = 3'd1;
    localparam logic [OP_W-1:0] OP_JMP  = 3'd2;
    localparam logic [OP_W-1:0] OP_BR   = 3'd3;
    localparam logic [OP_W-1:0] OP_CALL = 3'd4;
    localparam logic [OP_W-1:0] OP_RET  = 3'd5;

    // Stack index width; a single-entry stack still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ret_stack.sv
//------------------------------------------------------------------------------
// Module : ret_stack
// Brief  : LIFO of return addresses; entry storage is deliberately unreset.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ret_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [SPW-1:0]   sp,
    output logic             full,
    output logic             empty
);

    localparam int AW = idx_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign w_wr_idx = sp_q[AW-1:0];
    assign w_rd_idx = AW'(sp_q - SPW'(1));

    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);
    assign sp    = sp_q;
    assign top   = mem_q[w_rd_idx];

    always_ff @(posedge clkin) begin
        if (reset) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SPW'(1);
        end
    end

    // Entries above sp are never read, so the array needs no reset.
    always_ff @(posedge clkin) begin
        if (!reset && push && !full) begin
            mem_q[w_wr_idx] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// Module : pc_sequencer
// Brief  : Program counter with jump/branch/call/return and sticky fault.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          WIDTH        = 8,
    parameter int          DEPTH        = 4,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                         clkin,
    input  logic                         reset,
    input  logic                         en,
    input  logic [OP_W-1:0]              op,
    input  logic                         cond,
    input  logic [WIDTH-1:0]             target,
    input  logic [WIDTH-1:0]             offset,
    output logic [WIDTH-1:0]             pc,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         full,
    output logic                         empty,
    output logic                         fault
);

    localparam int SPW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             fault_q;
    logic             fault_d;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_top;
    logic             w_full;
    logic             w_empty;

    assign w_pc_inc = pc_q + WIDTH'(1);

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_ret_stack (
        .clkin (clkin),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .top   (w_top),
        .sp    (sp),
        .full  (w_full),
        .empty (w_empty)
    );

    // A raised fault freezes everything: no op is decoded until reset.
    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        if (en && !fault_q) begin
            case (op)
                OP_INC:  pc_d = w_pc_inc;
                OP_HOLD: pc_d = pc_q;
                OP_JMP:  pc_d = target;
                OP_BR:   pc_d = cond ? (pc_q + offset) : w_pc_inc;
                OP_CALL: begin
                    if (w_full) begin
                        fault_d = 1'b1;
                    end else begin
                        w_push = 1'b1;
                        pc_d   = target;
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        fault_d = 1'b1;
                    end else begin
                        w_pop = 1'b1;
                        pc_d  = w_top;
                    end
                end
                default: fault_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            pc_q    <= WIDTH'(RESET_VECTOR);
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign pc    = pc_q;
    assign fault = fault_q;
    assign full  = w_full;
    assign empty = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_pc_sequencer
// Brief  : Vector-table and scoreboard bench for pc_sequencer (8-bit, 4-deep).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

    localparam logic [2:0] C_INC  = 3'd0;
    localparam logic [2:0] C_HOLD = 3'd1;
    localparam logic [2:0] C_JMP  = 3'd2;
    localparam logic [2:0] C_BR   = 3'd3;
    localparam logic [2:0] C_CALL = 3'd4;
    localparam logic [2:0] C_RET  = 3'd5;

    logic       clkin;
    logic       reset;
    logic       en;
    logic [2:0] op;
    logic       cond;
    logic [7:0] target;
    logic [7:0] offset;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       full;
    logic       empty;
    logic       fault;

    pc_sequencer #(
        .WIDTH        (8),
        .DEPTH        (4),
        .RESET_VECTOR (0)
    ) dut (
        .clkin  (clkin),
        .reset  (reset),
        .en     (en),
        .op     (op),
        .cond   (cond),
        .target (target),
        .offset (offset),
        .pc     (pc),
        .sp     (sp),
        .full   (full),
        .empty  (empty),
        .fault  (fault)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] op;
        logic       cond;
        logic [7:0] target;
        logic [7:0] offset;
        logic [7:0] pc;
        logic [2:0] sp;
        logic       fault;
    } vec_t;

    typedef struct {
        logic [7:0] pc;
        logic [2:0] sp;
        logic       full;
        logic       empty;
        logic       fault;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] o,
                                input logic c, input logic [7:0] t, input logic [7:0] f,
                                input logic [7:0] p, input logic [2:0] s, input logic flt);
        vec_t v;
        v.rst = r; v.en = e; v.op = o; v.cond = c; v.target = t; v.offset = f;
        v.pc = p; v.sp = s; v.fault = flt;
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: no expected entry for output, pc=%h sp=%0d", pc, sp);
        end else begin
            e = sb.pop_front();
            if (pc !== e.pc || sp !== e.sp || full !== e.full || empty !== e.empty || fault !== e.fault) begin
                n_err++;
                $display("FAIL vec%0d: got pc=%h sp=%0d full=%b empty=%b fault=%b, expected pc=%h sp=%0d full=%b empty=%b fault=%b",
                         e.tag, pc, sp, full, empty, fault, e.pc, e.sp, e.full, e.empty, e.fault);
            end
        end
    endtask

    task automatic apply(input vec_t v, input int tag);
        exp_t e;
        reset  = v.rst;
        en     = v.en;
        op     = v.op;
        cond   = v.cond;
        target = v.target;
        offset = v.offset;
        e.pc    = v.pc;
        e.sp    = v.sp;
        e.full  = (v.sp == 3'd4);
        e.empty = (v.sp == 3'd0);
        e.fault = v.fault;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clkin);
        #1;
        check_out();
    endtask

    logic [7:0] stk[$];
    logic [7:0] mpc;
    logic [7:0] tgt;

    initial begin
        //            rst en op      c  target offset  pc     sp  fault
        vecs.push_back(mk(1, 0, C_INC,  0, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, C_INC,  0, 8'h00, 8'h00, 8'h01, 0, 0));
        vecs.push_back(mk(0, 1, C_INC,  0, 8'h00, 8'h00, 8'h02, 0, 0));
        vecs.push_back(mk(0, 1, C_INC,  0, 8'h00, 8'h00, 8'h03, 0, 0));
        vecs.push_back(mk(0, 1, C_HOLD, 0, 8'h77, 8'h00, 8'h03, 0, 0));
        vecs.push_back(mk(0, 1, C_JMP,  0, 8'hFE, 8'h00, 8'hFE, 0, 0));
        vecs.push_back(mk(0, 1, C_INC,  0, 8'h00, 8'h00, 8'hFF, 0, 0));
        vecs.push_back(mk(0, 1, C_INC,  0, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, C_JMP,  0, 8'h10, 8'h00, 8'h10, 0, 0));
        vecs.push_back(mk(0, 1, C_BR,   1, 8'h00, 8'hF8, 8'h08, 0, 0));
        vecs.push_back(mk(0, 1, C_BR,   0, 8'h00, 8'h05, 8'h09, 0, 0));
        vecs.push_back(mk(0, 1, C_JMP,  0, 8'h20, 8'h00, 8'h20, 0, 0));
        vecs.push_back(mk(0, 1, C_CALL, 0, 8'h40, 8'h00, 8'h40, 1, 0));
        vecs.push_back(mk(0, 1, C_CALL, 0, 8'h50, 8'h00, 8'h50, 2, 0));
        vecs.push_back(mk(0, 1, C_RET,  0, 8'h00, 8'h00, 8'h41, 1, 0));
        vecs.push_back(mk(0, 1, C_RET,  0, 8'h00, 8'h00, 8'h21, 0, 0));
        vecs.push_back(mk(0, 0, C_INC,  0, 8'h00, 8'h00, 8'h21, 0, 0));
        vecs.push_back(mk(0, 0, C_RET,  0, 8'h00, 8'h00, 8'h21, 0, 0));
        vecs.push_back(mk(0, 0, 3'd7,   0, 8'h00, 8'h00, 8'h21, 0, 0));
        vecs.push_back(mk(0, 1, C_CALL, 0, 8'h60, 8'h00, 8'h60, 1, 0));
        vecs.push_back(mk(0, 1, C_CALL, 0, 8'h61, 8'h00, 8'h61, 2, 0));
        vecs.push_back(mk(0, 1, C_CALL, 0, 8'h62, 8'h00, 8'h62, 3, 0));
        vecs.push_back(mk(0, 1, C_CALL, 0, 8'h63, 8'h00, 8'h63, 4, 0));
        vecs.push_back(mk(0, 1, C_CALL, 0, 8'h70, 8'h00, 8'h63, 4, 1));
        vecs.push_back(mk(0, 1, C_INC,  0, 8'h00, 8'h00, 8'h63, 4, 1));
        vecs.push_back(mk(0, 1, C_RET,  0, 8'h00, 8'h00, 8'h63, 4, 1));
        vecs.push_back(mk(1, 1, C_CALL, 0, 8'h99, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, C_RET,  0, 8'h00, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, C_JMP,  0, 8'h33, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk(1, 0, C_INC,  0, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 3'd6,   0, 8'h44, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk(1, 0, C_INC,  0, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, C_BR,   1, 8'h00, 8'hFF, 8'hFF, 0, 0));
        vecs.push_back(mk(0, 1, C_CALL, 0, 8'h80, 8'h00, 8'h80, 1, 0));
        vecs.push_back(mk(1, 1, C_RET,  0, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, C_RET,  0, 8'h00, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk(1, 0, C_INC,  0, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, C_CALL, 0, 8'h90, 8'h00, 8'h90, 1, 0));
        vecs.push_back(mk(0, 1, C_RET,  0, 8'h00, 8'h00, 8'h01, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Nested calls to full depth, unwound against a reference stack.
        apply(mk(1, 0, C_INC, 0, 8'h00, 8'h00, 8'h00, 0, 0), 100);
        apply(mk(0, 1, C_JMP, 0, 8'h10, 8'h00, 8'h10, 0, 0), 101);
        mpc = 8'h10;
        for (int i = 0; i < 4; i++) begin
            tgt = 8'h30 + 8'(i * 16);
            stk.push_back(mpc + 8'd1);
            mpc = tgt;
            apply(mk(0, 1, C_CALL, 0, tgt, 8'h00, mpc, 3'(stk.size()), 0), 110 + i);
        end
        for (int i = 0; i < 4; i++) begin
            mpc = stk.pop_back();
            apply(mk(0, 1, C_RET, 0, 8'h00, 8'h00, mpc, 3'(stk.size()), 0), 120 + i);
        end

        // Stall with mixed ops, then resume counting from the held value.
        for (int i = 0; i < 3; i++) begin
            apply(mk(0, 0, 3'(i * 2), 1, 8'hAA, 8'h10, mpc, 0, 0), 130 + i);
        end
        apply(mk(0, 1, C_INC, 0, 8'h00, 8'h00, mpc + 8'd1, 0, 0), 140);

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, PC and address width in bits (legal 4..32).
REQ-002 Parameter DEPTH, default 4, return-stack entries (legal 1..16).
REQ-003 Parameter RESET_VECTOR, default 0, PC value after reset.
REQ-004 Port clkin  in  1  sole clock; all state updates on the rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port en  in  1  advance enable; 0 = stall, no state change.
REQ-007 Port op  in  3  operation select: 0 INC, 1 HOLD, 2 JMP, 3 BR, 4 CALL, 5 RET, 6-7 reserved.
REQ-008 Port cond  in  1  branch condition, used by BR only.
REQ-009 Port target  in  WIDTH  absolute destination for JMP and CALL.
REQ-010 Port offset  in  WIDTH  two's-complement displacement for BR.
REQ-011 Port pc  out  WIDTH  current program counter, registered.
REQ-012 Port sp  out  $clog2(DEPTH+1)  number of occupied stack entries, registered.
REQ-013 Port full  out  1  sp == DEPTH.
REQ-014 Port empty  out  1  sp == 0.
REQ-015 Port fault  out  1  sticky error flag, registered.

Function
REQ-016 When en=1 and fault=0, the block SHALL apply op to pc and the stack, with the result visible one cycle after the sampling edge.
REQ-017 INC SHALL set pc <= pc+1 modulo 2^WIDTH, so that all-ones wraps to 0.
REQ-018 HOLD SHALL leave pc and the stack unchanged.
REQ-019 JMP SHALL set pc <= target.
REQ-020 BR SHALL set pc <= pc+offset modulo 2^WIDTH when cond=1, and SHALL behave as INC when cond=0.
REQ-021 CALL with full=0 SHALL push pc+1 (mod 2^WIDTH) onto the stack, increment sp and set pc <= target, all in the same cycle.
REQ-022 RET with empty=0 SHALL set pc <= top entry and decrement sp.
REQ-023 CALL with full=1 (overflow) SHALL leave pc and the stack unchanged and set fault.
REQ-024 RET with empty=1 (underflow) SHALL leave pc and sp unchanged and set fault.
REQ-025 A reserved op (6, 7) SHALL leave pc and the stack unchanged and set fault.
REQ-026 When en=0, the block SHALL hold pc, sp and fault regardless of op; no fault is raised.
REQ-027 Once fault=1, pc, sp and the stack SHALL hold until reset, regardless of en and op.
REQ-028 full, empty and fault SHALL be derived from or held in registers, with no combinational path from any input.
REQ-029 With DEPTH=1, one CALL SHALL fill the stack, and a second CALL before RET SHALL fault.

Reset
REQ-030 reset=1 at a rising edge SHALL set pc <= RESET_VECTOR, sp <= 0 and fault <= 0, overriding en and op.
REQ-031 Stack entry contents SHALL NOT be reset; reads below sp never occur.
REQ-032 A reset asserted mid-sequence (for example between CALL and RET) SHALL discard all pending return addresses.

Structure
REQ-033 The op encodings (OP_INC..OP_RET) SHALL be defined as named constants in the shared package pc_pkg.
REQ-034 The return stack SHALL be a separate sub-module ret_stack(WIDTH, DEPTH) with push, pop, top, sp, full and empty ports.
REQ-035 pc_sequencer SHALL contain only the next-PC selection, the fault register and the pc register.

Verification (WIDTH=8, DEPTH=4, RESET_VECTOR=0x00)
REQ-036 Reset, then 3 cycles of INC with en=1 -> pc = 0x00, 0x01, 0x02, 0x03; sp=0, empty=1, fault=0.
REQ-037 JMP target=0xFE, then INC, INC -> pc = 0xFE, 0xFF, 0x00 (wrap-around).
REQ-038 At pc=0x10: BR offset=0xF8 cond=1 -> pc=0x08; then BR offset=0x05 cond=0 -> pc=0x09.
REQ-039 At pc=0x20: CALL 0x40, then CALL 0x50, then RET, RET -> pc = 0x40, 0x50, 0x41, 0x21; sp = 1, 2, 1, 0.
REQ-040 Four CALLs (full=1), then a fifth CALL -> fault=1 and pc unchanged; subsequent INC keeps pc; reset -> pc=0x00, fault=0, sp=0.
REQ-041 RET at sp=0 -> fault=1; separately, with en=0 for 3 cycles under INC -> pc constant, fault=0.
